// File: rtl/serdes_word_aligner.sv
// -----------------------------------------------------------------------------
// serdes_word_aligner
//   Word-alignment stage behind an ISERDESE3, running on the divided clock.
//   Raw words have an arbitrary bit boundary. The block walks a bit offset
//   across a two-word window until TRAIN_PATTERN is seen LOCK_COUNT times in a
//   row. It then reports lock and keeps delivering aligned words.
//
//   Optional build macro:
//     SERDES_ALIGNER_BITREV_EN - bit-reverse din before it enters the window,
//                                for MSB-first sources.
//
//   Ports:
//     clk        in   divided clock (ISERDESE3 CLKDIV)
//     rst_n      in   asynchronous active-low reset
//     din        in   raw word, bit 0 earliest
//     din_valid  in   qualifies din
//     train_en   in   enables pattern checking; low freezes FSM and counters
//     realign    in   one-cycle pulse forcing a new search
//     dout       out  aligned word
//     dout_valid out  qualifies dout (din_valid delayed by one cycle)
//     locked     out  high while in LOCKED
//     offset     out  current bit offset into the window
//     sweep_fail out  sticky: a full offset sweep ended without lock
// -----------------------------------------------------------------------------
module serdes_word_aligner #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int unsigned           LOCK_COUNT    = 16,
  parameter int unsigned           ERR_LIMIT     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  input  logic                          train_en,
  input  logic                          realign,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          locked,
  output logic [$clog2(DATA_WIDTH)-1:0] offset,
  output logic                          sweep_fail
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_BLANK,
    S_VERIFY,
    S_LOCKED
  } state_e;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   din_w;
  logic [2*DATA_WIDTH-1:0] window_w;
  logic [DATA_WIDTH-1:0]   prev_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    dout_valid_q;

`ifdef SERDES_ALIGNER_BITREV_EN
  always_comb begin
    din_w = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      din_w[i] = din[DATA_WIDTH-1-i];
    end
  end
`else
  always_comb begin
    din_w = din;
  end
`endif

  // Bit 0 of the window is the oldest bit (from the previous word).
  always_comb begin
    window_w = {din_w, prev_q};
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM and counters
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic               sweep_fail_q, sweep_fail_d;
  logic               word_w;
  logic               match_w;
  logic               slip_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= din_valid;
      if (din_valid) begin
        prev_q <= din_w;
        dout_q <= window_w[offset_q +: DATA_WIDTH];
      end
    end
  end

  // A word is a qualified output word while checking is enabled; the
  // comparison always uses the registered dout.
  always_comb begin
    word_w  = dout_valid_q & train_en;
    match_w = (dout_q == TRAIN_PATTERN);
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    sweep_fail_d = sweep_fail_q;
    slip_w       = 1'b0;

    if (realign) begin
      // Offset is kept so a re-search starts from the last known position.
      state_d      = S_SEARCH;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
      slip_cnt_d   = '0;
      sweep_fail_d = 1'b0;
    end else if (word_w) begin
      unique case (state_q)
        S_SEARCH: begin
          if (match_w) begin
            match_cnt_d = CNT_W'(1);
            if (match_cnt_d == CNT_W'(LOCK_COUNT)) begin
              state_d   = S_LOCKED;
              err_cnt_d = '0;
            end else begin
              state_d = S_VERIFY;
            end
          end else begin
            slip_w = 1'b1;
          end
        end
        S_BLANK: begin
          // This word was produced with the pre-slip offset.
          state_d = S_SEARCH;
        end
        S_VERIFY: begin
          if (match_w) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (match_cnt_d == CNT_W'(LOCK_COUNT)) begin
              state_d   = S_LOCKED;
              err_cnt_d = '0;
            end
          end else begin
            slip_w = 1'b1;
          end
        end
        S_LOCKED: begin
          if (match_w) begin
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_d == CNT_W'(ERR_LIMIT)) begin
              state_d     = S_SEARCH;
              err_cnt_d   = '0;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase

      if (slip_w) begin
        state_d     = S_BLANK;
        match_cnt_d = '0;
        offset_d    = (offset_q == OFF_W'(DATA_WIDTH - 1)) ? '0 : offset_q + OFF_W'(1);
        if (slip_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          slip_cnt_d   = '0;
          sweep_fail_d = 1'b1;
        end else begin
          slip_cnt_d = slip_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SEARCH;
      offset_q     <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      sweep_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      sweep_fail_q <= sweep_fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dout       = dout_q;
    dout_valid = dout_valid_q;
    locked     = (state_q == S_LOCKED);
    offset     = offset_q;
    sweep_fail = sweep_fail_q;
  end

endmodule
